// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared defaults, FSM state type, width derivation helpers and
// the point/element packed types used by the centroid and assignment units.
package kmeans_pkg;

  localparam int K_DEF          = 14;
  localparam int DIMS_DEF       = 5;
  localparam int COORD_W_DEF    = 7;
  localparam int EPOCH_LEN_DEF  = 300;
  localparam int MAX_EPOCHS_DEF = 8;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Cluster id width; a single cluster still needs one id bit on the bus.
  function automatic int id_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  // Member counter width, must hold EPOCH_LEN itself.
  function automatic int cnt_w(input int epoch_len);
    return $clog2(epoch_len + 1);
  endfunction

  // Coordinate sum width: EPOCH_LEN maximal coordinates cannot overflow it.
  function automatic int sum_w(input int coord_w, input int epoch_len);
    return coord_w + cnt_w(epoch_len);
  endfunction

  typedef logic [DIMS_DEF-1:0][COORD_W_DEF-1:0] point_t;

  typedef struct packed {
    logic [id_w(K_DEF)-1:0] cluster_id;
    point_t                 point;
  } element_t;

endpackage

// File: rtl/kmeans_centroid_unit_div.sv
// kmeans_seq_div: restoring unsigned divider, one quotient bit per cycle.
// The dividend is W+1 bits but only W iterations run: the top dividend bit is
// preloaded into the partial remainder, which is valid because the caller
// guarantees the quotient never needs a bit at position W.
module kmeans_seq_div #(
  parameter int W     = 11,
  parameter int DVS_W = 3,
  parameter int Q_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W:0]       dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int IT_W = $clog2(W + 1);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IT_W-1:0]  iter_q, iter_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [W-1:0]     dvd_q, dvd_d;
  logic [DVS_W:0]   trial;

  // Load on start, then shift/subtract until the iteration timer expires.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    iter_d = iter_q;
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    trial  = {rem_q, dvd_q[W-1]};
    if (start) begin
      busy_d = 1'b1;
      iter_d = IT_W'(W);
      rem_d  = DVS_W'(dividend[W]);
      dvd_d  = dividend[W-1:0];
    end else if (busy_q) begin
      if (trial >= {1'b0, divisor}) begin
        rem_d = DVS_W'(trial - {1'b0, divisor});
        dvd_d = {dvd_q[W-2:0], 1'b1};
      end else begin
        rem_d = trial[DVS_W-1:0];
        dvd_d = {dvd_q[W-2:0], 1'b0};
      end
      iter_d = iter_q - IT_W'(1);
      if (iter_q == IT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      iter_q <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      iter_q <= iter_d;
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
    end
  end

  assign done     = done_q;
  assign quotient = dvd_q[Q_W-1:0];

endmodule

// File: rtl/kmeans_centroid_unit.sv
// kmeans_centroid_unit: per-cluster accumulate, epoch-end divide, publish.
// Optional build macro KMEANS_ROUND_EN selects round-to-nearest (ties up)
// division; otherwise the centroid quotient is truncated.
//
// state  | meaning
// ACCUM  | accept elements, accumulate sums and counts
// DIVIDE | sequentially compute sum/cnt into the shadow array
// UPDATE | publish shadow, clear accumulators, bump epoch number
// DONE   | all epochs complete, hold centroids until reset
module kmeans_centroid_unit
  import kmeans_pkg::*;
#(
  parameter  int K          = K_DEF,
  parameter  int DIMS       = DIMS_DEF,
  parameter  int COORD_W    = COORD_W_DEF,
  parameter  int EPOCH_LEN  = EPOCH_LEN_DEF,
  parameter  int MAX_EPOCHS = MAX_EPOCHS_DEF,
  localparam int ID_W       = id_w(K),
  localparam int POINT_W    = DIMS * COORD_W,
  localparam int CNT_W      = cnt_w(EPOCH_LEN),
  localparam int SUM_W      = sum_w(COORD_W, EPOCH_LEN)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          training,
  input  logic                          valid,
  input  logic [ID_W+POINT_W-1:0]       element_in,
  input  logic                          init_load,
  input  logic [K-1:0][POINT_W-1:0]     init_centroids,
  output logic                          ready,
  output logic [K-1:0][POINT_W-1:0]     formatted_centroids,
  output logic                          recalculate_centroids,
  output logic                          update_centroids,
  output logic                          finished
);

  localparam int DIM_IW = (DIMS > 1) ? $clog2(DIMS) : 1;
  localparam int EN_W   = $clog2(MAX_EPOCHS + 1);

  localparam logic [ID_W:0]     K_LIM      = (ID_W + 1)'(K);
  localparam logic [ID_W-1:0]   C_LAST     = ID_W'(K - 1);
  localparam logic [DIM_IW-1:0] D_LAST     = DIM_IW'(DIMS - 1);
  localparam logic [CNT_W-1:0]  EPOCH_LAST = CNT_W'(EPOCH_LEN - 1);
  localparam logic [EN_W-1:0]   EPOCH_MAX  = EN_W'(MAX_EPOCHS);

  typedef logic [DIMS-1:0][COORD_W-1:0] pt_t;

  state_e                             state_q, state_d;
  logic [SUM_W-1:0]                   sum_q [K][DIMS];
  logic [SUM_W-1:0]                   sum_d [K][DIMS];
  logic [CNT_W-1:0]                   cnt_q [K];
  logic [CNT_W-1:0]                   cnt_d [K];
  logic [CNT_W-1:0]                   epoch_cnt_q, epoch_cnt_d;
  logic [EN_W-1:0]                    epoch_num_q, epoch_num_d;
  logic [K-1:0][DIMS-1:0][COORD_W-1:0] cent_q, cent_d;
  logic [K-1:0][DIMS-1:0][COORD_W-1:0] shadow_q, shadow_d;
  logic                               recalc_q, recalc_d;
  logic                               issue_q, issue_d;
  logic [ID_W-1:0]                    c_idx_q, c_idx_d;
  logic [DIM_IW-1:0]                  d_idx_q, d_idx_d;

  logic [ID_W-1:0]  in_id;
  pt_t              in_pt;
  logic             accept;
  logic             div_done;
  logic [SUM_W:0]   div_dividend;
  logic [CNT_W-1:0] div_divisor;
  logic [COORD_W-1:0] div_quot;

  assign in_id  = element_in[POINT_W +: ID_W];
  assign in_pt  = element_in[POINT_W-1:0];
  assign ready  = (state_q == ST_ACCUM);
  assign accept = valid & ready & training;

  assign div_divisor = cnt_q[c_idx_q];
`ifdef KMEANS_ROUND_EN
  assign div_dividend = {1'b0, sum_q[c_idx_q][d_idx_q]} + (SUM_W + 1)'(div_divisor >> 1);
`else
  assign div_dividend = {1'b0, sum_q[c_idx_q][d_idx_q]};
`endif

  kmeans_seq_div #(
    .W     (SUM_W),
    .DVS_W (CNT_W),
    .Q_W   (COORD_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (issue_q),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Next-state, accumulation, divide sequencing and centroid publishing.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    epoch_cnt_d = epoch_cnt_q;
    epoch_num_d = epoch_num_q;
    cent_d      = cent_q;
    shadow_d    = shadow_q;
    recalc_d    = 1'b0;
    issue_d     = 1'b0;
    c_idx_d     = c_idx_q;
    d_idx_d     = d_idx_q;

    if (init_load && ready && (epoch_cnt_q == '0)) begin
      cent_d = init_centroids;
    end

    case (state_q)
      ST_ACCUM: begin
        if (accept && ({1'b0, in_id} < K_LIM)) begin
          for (int d = 0; d < DIMS; d++) begin
            sum_d[in_id][d] = sum_q[in_id][d] + SUM_W'(in_pt[d]);
          end
          cnt_d[in_id] = cnt_q[in_id] + CNT_W'(1);
          epoch_cnt_d  = epoch_cnt_q + CNT_W'(1);
          if (epoch_cnt_q == EPOCH_LAST) begin
            state_d  = ST_DIVIDE;
            recalc_d = 1'b1;
            issue_d  = 1'b1;
            c_idx_d  = '0;
            d_idx_d  = '0;
          end
        end
      end
      ST_DIVIDE: begin
        if (div_done) begin
          // An empty cluster keeps its current centroid.
          shadow_d[c_idx_q][d_idx_q] = (div_divisor != '0) ? div_quot
                                                           : cent_q[c_idx_q][d_idx_q];
          if (d_idx_q == D_LAST) begin
            d_idx_d = '0;
            if (c_idx_q == C_LAST) begin
              state_d = ST_UPDATE;
            end else begin
              c_idx_d = c_idx_q + ID_W'(1);
              issue_d = 1'b1;
            end
          end else begin
            d_idx_d = d_idx_q + DIM_IW'(1);
            issue_d = 1'b1;
          end
        end
      end
      ST_UPDATE: begin
        cent_d = shadow_q;
        for (int c = 0; c < K; c++) begin
          cnt_d[c] = '0;
          for (int d = 0; d < DIMS; d++) begin
            sum_d[c][d] = '0;
          end
        end
        epoch_cnt_d = '0;
        c_idx_d     = '0;
        epoch_num_d = epoch_num_q + EN_W'(1);
        state_d     = (epoch_num_d == EPOCH_MAX) ? ST_DONE : ST_ACCUM;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State, accumulator and centroid registers; reset discards any partial shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      epoch_cnt_q <= '0;
      epoch_num_q <= '0;
      cent_q      <= '0;
      shadow_q    <= '0;
      recalc_q    <= 1'b0;
      issue_q     <= 1'b0;
      c_idx_q     <= '0;
      d_idx_q     <= '0;
      for (int c = 0; c < K; c++) begin
        cnt_q[c] <= '0;
        for (int d = 0; d < DIMS; d++) begin
          sum_q[c][d] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      epoch_cnt_q <= epoch_cnt_d;
      epoch_num_q <= epoch_num_d;
      cent_q      <= cent_d;
      shadow_q    <= shadow_d;
      recalc_q    <= recalc_d;
      issue_q     <= issue_d;
      c_idx_q     <= c_idx_d;
      d_idx_q     <= d_idx_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
    end
  end

  assign formatted_centroids   = cent_q;
  assign recalculate_centroids = recalc_q;
  assign update_centroids      = (state_q == ST_UPDATE);
  assign finished              = (state_q == ST_DONE);

endmodule

// File: tb/tb_kmeans_centroid_unit.sv
// tb_kmeans_centroid_unit: directed vectors with hand-computed centroids.
// Main instance: K=2, DIMS=2, COORD_W=8, EPOCH_LEN=4, MAX_EPOCHS=2.
// A second K=3 instance exercises dropping of an out-of-range cluster id.
`timescale 1ns/1ps
module tb_kmeans_centroid_unit;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            training = 1'b1;
  logic            valid = 1'b0;
  logic            init_load = 1'b0;
  logic [16:0]     element_in = '0;
  logic [1:0][15:0] init_centroids = '0;
  logic [1:0][15:0] formatted_centroids;
  logic            ready, recalc, update, finished;

  logic            valid2 = 1'b0;
  logic [17:0]     element2 = '0;
  logic [2:0][15:0] init2 = '0;
  logic [2:0][15:0] formatted2;
  logic            ready2, recalc2, update2, finished2;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef KMEANS_ROUND_EN
  localparam logic [15:0] C1_E1 = 16'h3365;  // (101,51)
  localparam logic [15:0] C0_E2 = 16'h0907;  // (7,9)
`else
  localparam logic [15:0] C1_E1 = 16'h3264;  // (100,50)
  localparam logic [15:0] C0_E2 = 16'h0807;  // (7,8)
`endif
  localparam logic [15:0] C0_E1 = 16'h150B;  // (11,21)

  kmeans_centroid_unit #(
    .K(2), .DIMS(2), .COORD_W(8), .EPOCH_LEN(4), .MAX_EPOCHS(2)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .training              (training),
    .valid                 (valid),
    .element_in            (element_in),
    .init_load             (init_load),
    .init_centroids        (init_centroids),
    .ready                 (ready),
    .formatted_centroids   (formatted_centroids),
    .recalculate_centroids (recalc),
    .update_centroids      (update),
    .finished              (finished)
  );

  kmeans_centroid_unit #(
    .K(3), .DIMS(2), .COORD_W(8), .EPOCH_LEN(4), .MAX_EPOCHS(2)
  ) dut3 (
    .clk                   (clk),
    .reset                 (reset),
    .training              (training),
    .valid                 (valid2),
    .element_in            (element2),
    .init_load             (1'b0),
    .init_centroids        (init2),
    .ready                 (ready2),
    .formatted_centroids   (formatted2),
    .recalculate_centroids (recalc2),
    .update_centroids      (update2),
    .finished              (finished2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic id, input logic [7:0] x, input logic [7:0] y);
    element_in = {id, y, x};
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic send2(input logic [1:0] id, input logic [7:0] x, input logic [7:0] y);
    element2 = {id, y, x};
    valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
  endtask

  task automatic wait_upd(input bit sel, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((sel ? update2 : update) !== 1'b1) && (n < 200));
  endtask

  initial begin
    int n;
    int upd_seen;

    repeat (3) tick();
    reset = 1'b0;
    check_eq("rst_cent", formatted_centroids, 64'h0);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_recalc", recalc, 0);
    check_eq("rst_update", update, 0);
    check_eq("rst_finished", finished, 0);

    // Initial centroid load, then a second load after one accept is ignored.
    init_centroids = 32'h0202_0101;
    init_load = 1'b1;
    tick();
    init_load = 1'b0;
    check_eq("init_load", formatted_centroids, 32'h0202_0101);
    send(1'b0, 8'd10, 8'd20);
    init_centroids = 32'h0909_0909;
    init_load = 1'b1;
    tick();
    init_load = 1'b0;
    check_eq("init_ignored", formatted_centroids, 32'h0202_0101);

    // Epoch 1.
    send(1'b0, 8'd12, 8'd22);
    send(1'b1, 8'd100, 8'd50);
    send(1'b1, 8'd101, 8'd51);
    check_eq("e1_recalc", recalc, 1);
    check_eq("e1_ready_low", ready, 0);
    element_in = {1'b1, 8'd200, 8'd200};
    valid = 1'b1;
    tick();
    check_eq("e1_recalc_pulse", recalc, 0);
    repeat (19) tick();
    check_eq("e1_cent_hold", formatted_centroids, 32'h0202_0101);
    wait_upd(1'b0, n);
    valid = 1'b0;
    check_eq("e1_div_len", 20 + n, 52);
    tick();
    check_eq("e1_update_pulse", update, 0);
    check_eq("e1_cent", formatted_centroids, {C1_E1, C0_E1});
    check_eq("e1_ready_back", ready, 1);

    // Epoch 2: training low blocks accepts, all members go to c0.
    training = 1'b0;
    element_in = {1'b0, 8'd255, 8'd255};
    valid = 1'b1;
    repeat (3) tick();
    check_eq("no_train_ready", ready, 1);
    valid = 1'b0;
    training = 1'b1;
    send(1'b0, 8'd4, 8'd8);
    send(1'b0, 8'd6, 8'd8);
    send(1'b0, 8'd8, 8'd9);
    check_eq("e2_not_yet", recalc, 0);
    send(1'b0, 8'd10, 8'd10);
    check_eq("e2_recalc", recalc, 1);
    element_in = {1'b0, 8'd1, 8'd1};
    valid = 1'b1;
    wait_upd(1'b0, n);
    valid = 1'b0;
    check_eq("e2_div_len", n, 52);
    tick();
    check_eq("e2_cent", formatted_centroids, {C1_E1, C0_E2});
    check_eq("done_finished", finished, 1);
    check_eq("done_ready", ready, 0);

    // DONE ignores further elements.
    element_in = {1'b1, 8'd5, 8'd5};
    valid = 1'b1;
    repeat (5) tick();
    valid = 1'b0;
    check_eq("done_cent_hold", formatted_centroids, {C1_E1, C0_E2});
    check_eq("done_sticky", finished, 1);
    check_eq("done_ready_low", ready, 0);
    check_eq("done_no_recalc", recalc, 0);

    // Reset out of DONE.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst2_finished", finished, 0);
    check_eq("rst2_ready", ready, 1);
    check_eq("rst2_cent", formatted_centroids, 64'h0);

    // Reset in the middle of DIVIDE.
    init_centroids = 32'h0202_0101;
    init_load = 1'b1;
    tick();
    init_load = 1'b0;
    repeat (4) send(1'b0, 8'd1, 8'd1);
    repeat (20) tick();
    check_eq("mid_div_cent", formatted_centroids, 32'h0202_0101);
    check_eq("mid_div_ready", ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_cent", formatted_centroids, 64'h0);
    check_eq("mid_rst_ready", ready, 1);
    check_eq("mid_rst_update", update, 0);
    upd_seen = 0;
    repeat (60) begin
      tick();
      if (update === 1'b1) upd_seen++;
    end
    check_eq("mid_rst_no_update", upd_seen, 0);
    check_eq("mid_rst_cent_hold", formatted_centroids, 64'h0);

    // Out-of-range id on the K=3 instance is dropped and not counted.
    send2(2'd0, 8'd10, 8'd10);
    send2(2'd3, 8'd200, 8'd200);
    send2(2'd1, 8'd20, 8'd20);
    send2(2'd3, 8'd50, 8'd50);
    send2(2'd2, 8'd30, 8'd30);
    check_eq("drop_ready", ready2, 1);
    send2(2'd0, 8'd12, 8'd12);
    check_eq("drop_recalc", recalc2, 1);
    wait_upd(1'b1, n);
    check_eq("k3_div_len", n, 78);
    tick();
    check_eq("k3_cent", formatted2, 48'h1E1E_1414_0B0B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
